ssd_scan_driver: RTL and testbench

- Downstream stage of the lock controller: consumes the 20-bit, 4-digit code word `ssd` (4 × 5-bit symbol codes) and drives the multiplexed, active-low 4-digit seven-segment display through `AN` and `seven_out`.
- Does time-multiplexed digit scanning, symbol-to-segment decoding, frame-coherent snapshotting of the code word, per-digit 1 Hz blinking and anti-ghosting blanking.

---
 rtl/ssd_scan_driver.sv | 118 +++++++++++
 tb/tb_ssd_scan_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - 4-digit multiplexed seven-segment scan driver
// Frame-coherent code snapshot, per-digit blink and guard-window blanking.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_END    = RW'(GUARD_CYC);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    CODE_BLANK   = 5'd19;

  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [19:0]   r_snap;
  logic [3:0]    r_mask;
  logic          r_load_pending;

  logic          w_tick;
  logic [4:0]    w_code;
  logic [6:0]    w_seg;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b1000000;
      5'd1:    decode = 7'b1111001;
      5'd2:    decode = 7'b0100100;
      5'd3:    decode = 7'b0110000;
      5'd4:    decode = 7'b0011001;
      5'd5:    decode = 7'b0010010;
      5'd6:    decode = 7'b0000010;
      5'd7:    decode = 7'b1111000;
      5'd8:    decode = 7'b0000000;
      5'd9:    decode = 7'b0010000;
      5'd10:   decode = 7'b1000110;
      5'd11:   decode = 7'b1000111;
      5'd12:   decode = 7'b0010010;
      5'd13:   decode = 7'b0100001;
      5'd14:   decode = 7'b1000000;
      5'd15:   decode = 7'b0001100;
      5'd16:   decode = 7'b0000110;
      5'd17:   decode = 7'b0101011;
      5'd18:   decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign w_tick = (r_refresh_cnt == REFRESH_LAST);

  always_comb begin
    w_code = CODE_BLANK;
    case (r_idx)
      2'd3: w_code = r_snap[19:15];
      2'd2: w_code = r_snap[14:10];
      2'd1: w_code = r_snap[9:5];
      2'd0: w_code = r_snap[4:0];
      default: w_code = CODE_BLANK;
    endcase
  end

  assign w_seg = decode(w_code);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_refresh_cnt  <= '0;
      r_idx          <= 2'd3;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_snap         <= {4{CODE_BLANK}};
      r_mask         <= 4'b0000;
      r_load_pending <= 1'b1;
      AN             <= 4'b1111;
      seven_out      <= 7'b1111111;
    end else begin
      if (w_tick) begin
        r_refresh_cnt <= '0;
        r_idx         <= r_idx - 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end

      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      // Reload only at a frame boundary so a displayed frame is never torn.
      if (r_load_pending || (w_tick && r_idx == 2'd0)) begin
        r_snap         <= ssd;
        r_mask         <= blink_mask;
        r_load_pending <= 1'b0;
      end

      if (r_refresh_cnt < GUARD_END) begin
        AN        <= 4'b1111;
        seven_out <= 7'b1111111;
      end else begin
        AN        <= ~(4'b0001 << r_idx);
        seven_out <= (r_blink_phase && r_mask[r_idx]) ? 7'b1111111 : w_seg;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver
// Cycle model derived from elapsed cycles since reset, plus directed sequences.
module tb_ssd_scan_driver;

  localparam int R = 4;
  localparam int G = 1;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] ssd = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  AN;
  logic [6:0]  seven_out;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [23:0] hist[$];
  logic [6:0]  dec_tab[32];

  typedef struct {
    logic [4:0] code;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[23];

  ssd_scan_driver #(.REFRESH_DIV(R), .GUARD_CYC(G), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .ssd(ssd), .blink_mask(blink_mask),
    .AN(AN), .seven_out(seven_out)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; expected outputs come from cycle arithmetic and recorded inputs.
  task automatic step();
    logic [23:0] s;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic [4:0]  code;
    int f, le, r, ix, ph;
    @(posedge clk);
    if (!rst) begin
      ea = 4'hF;
      es = 7'h7F;
      k = 0;
      hist.delete();
    end else begin
      hist.push_back({blink_mask, ssd});
      f  = k / (4 * R);
      le = (f == 0) ? 0 : 4 * R * f - 1;
      s  = hist[le];
      r  = k % R;
      ix = 3 - ((k / R) % 4);
      ph = (k / B) % 2;
      code = s[ix*5 +: 5];
      if (r < G) begin
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = ~(4'b0001 << ix);
        es = (ph == 1 && s[20+ix]) ? 7'h7F : dec_tab[code];
      end
      k++;
    end
    #1;
    check("model_an", {28'd0, AN}, {28'd0, ea});
    check("model_seg", {25'd0, seven_out}, {25'd0, es});
  endtask

  task automatic wait_an(string name, logic [3:0] an, logic [6:0] seg);
    bit found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      step();
      if (AN == an) begin
        found = 1;
        check(name, {25'd0, seven_out}, {25'd0, seg});
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: anode %b not seen within 24 cycles", name, an);
    end
  endtask

  initial begin
    logic [6:0] scan_seg[4];
    logic [3:0] exp_an;
    int lit, blanked;

    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b1000110, 7'b1000111, 7'b0010010, 7'b0100001, 7'b1000000,
                7'b0001100, 7'b0000110, 7'b0101011, 7'b0111111, 7'b1111111,
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 20; i++) vecs[i] = '{5'(i), dec_tab[i]};
    vecs[20] = '{5'd20, 7'b1111111};
    vecs[21] = '{5'd25, 7'b1111111};
    vecs[22] = '{5'd31, 7'b1111111};

    // Reset and scan order
    rst = 1'b0;
    ssd = {5'd10, 5'd11, 5'd12, 5'd13};
    repeat (3) begin
      step();
      check("reset_an", {28'd0, AN}, 32'hF);
      check("reset_seg", {25'd0, seven_out}, 32'h7F);
    end
    rst = 1'b1;
    scan_seg = '{7'b1000110, 7'b1000111, 7'b0010010, 7'b0100001};
    for (int i = 0; i < 16; i++) begin
      step();
      exp_an = (i % 4 == 0) ? 4'hF : ~(4'b1000 >> (i / 4));
      check("scan_an", {28'd0, AN}, {28'd0, exp_an});
      check("scan_seg", {25'd0, seven_out},
            (i % 4 == 0) ? 32'h7F : {25'd0, scan_seg[i/4]});
    end

    // Frame coherence: change code word mid-frame while digit 2 is scanned
    repeat (6) step();
    ssd = {5'd14, 5'd15, 5'd16, 5'd17};
    wait_an("coh_d1_old", 4'b1101, 7'b0010010);
    wait_an("coh_d0_old", 4'b1110, 7'b0100001);
    wait_an("coh_d3_new", 4'b0111, 7'b1000000);
    wait_an("coh_d2_new", 4'b1011, 7'b0001100);
    wait_an("coh_d1_new", 4'b1101, 7'b0000110);
    wait_an("coh_d0_new", 4'b1110, 7'b0101011);

    // Decode table
    for (int v = 0; v < 23; v++) begin
      ssd = {4{vecs[v].code}};
      repeat (32) step();
      wait_an("decode", 4'b1011, vecs[v].seg);
    end

    // Blink
    ssd = {5'd0, 5'd19, 5'd19, 5'd19};
    blink_mask = 4'b1000;
    lit = 0;
    blanked = 0;
    repeat (32) step();
    for (int i = 0; i < 96; i++) begin
      step();
      if (AN == 4'b0111 && seven_out == 7'b1000000) lit++;
      if (AN == 4'b0111 && seven_out == 7'b1111111) blanked++;
    end
    check("blink_lit_seen", {31'd0, lit > 0}, 32'd1);
    check("blink_blank_seen", {31'd0, blanked > 0}, 32'd1);

    // Out-of-range and special codes
    blink_mask = 4'b0000;
    ssd = {5'd31, 5'd18, 5'd19, 5'd8};
    repeat (32) step();
    wait_an("oor_d3", 4'b0111, 7'b1111111);
    wait_an("oor_d2", 4'b1011, 7'b0111111);
    wait_an("oor_d1", 4'b1101, 7'b1111111);
    wait_an("oor_d0", 4'b1110, 7'b0000000);

    // Mid-scan reset while digit 1 is active
    wait_an("pre_rst_d1", 4'b1101, 7'b1111111);
    rst = 1'b0;
    step();
    check("midrst_an", {28'd0, AN}, 32'hF);
    check("midrst_seg", {25'd0, seven_out}, 32'h7F);
    rst = 1'b1;
    ssd = {5'd1, 5'd2, 5'd3, 5'd4};
    step();
    check("restart_guard", {28'd0, AN}, 32'hF);
    step();
    check("restart_an", {28'd0, AN}, 32'h7);
    check("restart_seg", {25'd0, seven_out}, {25'd0, 7'b1111001});

    // Random stimulus with anode invariant
    for (int i = 0; i < 2000; i++) begin
      ssd = 20'($urandom);
      blink_mask = 4'($urandom);
      step();
      check("an_onehot", {31'd0, $countones(~AN) <= 1}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
